// File: rtl/nand_io_pkg.sv
// Shared constants and helpers for the NAND input-conditioning stage.
//   DEBOUNCE_DEFAULT : stable cycles needed before a new level is accepted
//   SYNC_DEFAULT     : synchroniser depth per channel
//   clog2_min1()     : counter width helper that never returns 0
package nand_io_pkg;

  localparam int DEBOUNCE_DEFAULT = 1000;
  localparam int SYNC_DEFAULT     = 2;

  // $clog2 returns 0 for 1; a zero-width counter is not legal, so clamp to 1.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/nand_debounce_channel.sv
// One debounced input bit: synchroniser, stability counter, level register
// and registered edge strobes.
// Ports:
//   clk     : system clock
//   rst_n   : asynchronous active-low reset, clears every flop
//   ena     : low freezes the counter and level, and forces the strobes to 0
//   raw     : asynchronous pad level
//   clean   : debounced level
//   rise_p  : one-cycle strobe after clean goes 0->1
//   fall_p  : one-cycle strobe after clean goes 1->0
module nand_debounce_channel
  import nand_io_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_DEFAULT,     // must be >= 2
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT  // must be >= 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic raw,
  output logic clean,
  output logic rise_p,
  output logic fall_p
);

  localparam int              CNT_W   = clog2_min1(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CNT_W-1:0]       cnt;

  assign sync = sync_q[SYNC_STAGES-1];

  // The synchroniser ignores ena so the sampled level is current when
  // filtering resumes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Counter counts consecutive cycles where sync differs from clean. Any
  // return to the accepted level clears it, so a glitch earns no credit.
  // On the last count the new level is taken and the counter cleared, which
  // also keeps it from ever passing CNT_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      clean  <= 1'b0;
      rise_p <= 1'b0;
      fall_p <= 1'b0;
    end else begin
      rise_p <= 1'b0;
      fall_p <= 1'b0;
      if (ena) begin
        if (sync == clean) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          cnt    <= '0;
          clean  <= sync;
          rise_p <= sync;
          fall_p <= ~sync;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/nand_input_debouncer.sv
// Input-conditioning stage ahead of the NAND logic. Each raw pad bit is
// synchronised and debounced independently; only settled levels and
// one-cycle edge strobes leave this block.
// Ports:
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   ena        : design enable; low freezes filtering
//   raw_in     : asynchronous pad levels
//   clean_out  : debounced level per channel
//   rise_p     : per-channel 0->1 strobe
//   fall_p     : per-channel 1->0 strobe
//   any_change : OR of all strobes, one cycle wide
module nand_input_debouncer
  import nand_io_pkg::*;
#(
  parameter int N_CH            = 2,
  parameter int SYNC_STAGES     = SYNC_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise_p,
  output logic [N_CH-1:0] fall_p,
  output logic            any_change
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    nand_debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .raw   (raw_in[i]),
      .clean (clean_out[i]),
      .rise_p(rise_p[i]),
      .fall_p(fall_p[i])
    );
  end

  // Strobes are registered, so this OR stays one cycle wide even when
  // several channels change together, and no path from raw_in is created.
  assign any_change = |(rise_p | fall_p);

endmodule

// File: tb/tb_nand_input_debouncer.sv
module tb_nand_input_debouncer;

  localparam int N_CH = 2;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LAT  = SYNC + DEB;
  localparam int EW   = 20;  // {cycle[15:0], rise[1:0], fall[1:0]}

  logic            clk;
  logic            rst_n;
  logic            ena;
  logic [N_CH-1:0] raw_in;
  logic [N_CH-1:0] clean_out;
  logic [N_CH-1:0] rise_p;
  logic [N_CH-1:0] fall_p;
  logic            any_change;

  logic [15:0]   cyc;
  logic [EW-1:0] exp_q[$];
  int            chk_cnt;
  int            err_cnt;

  nand_input_debouncer #(
    .N_CH           (N_CH),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .raw_in    (raw_in),
    .clean_out (clean_out),
    .rise_p    (rise_p),
    .fall_p    (fall_p),
    .any_change(any_change)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 16'd1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected strobe event LAT cycles after a raw change driven now.
  task automatic expect_event(input int delay, input logic [1:0] r, input logic [1:0] f);
    logic [15:0] at;
    at = cyc + 16'(delay);
    exp_q.push_back({at, r, f});
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] got;
    check("any_or", any_change, |(rise_p | fall_p));
    check("rise_fall_excl", rise_p & fall_p, 0);
    if (any_change || (|rise_p) || (|fall_p)) begin
      got = {cyc, rise_p, fall_p};
      if (exp_q.size() == 0) check("spurious_pulse", got, 0);
      else                   check("pulse_event", got, exp_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    cyc     = 16'd0;
    chk_cnt = 0;
    err_cnt = 0;
    rst_n   = 1'b0;
    ena     = 1'b1;
    raw_in  = 2'b11;

    // 1. Reset holds everything at 0, then a high input is accepted.
    wait_cycles(3);
    check("rst_clean", clean_out, 0);
    check("rst_rise", rise_p, 0);
    check("rst_fall", fall_p, 0);
    check("rst_any", any_change, 0);
    rst_n = 1'b1;
    expect_event(LAT, 2'b11, 2'b00);
    drain("drain_reset");
    check("t1_clean", clean_out, 2'b11);

    // 2. Bounce on channel 0: drop it first, then bounce and settle high.
    raw_in = 2'b10;
    expect_event(LAT, 2'b00, 2'b01);
    drain("drain_fall0");
    check("t2_low", clean_out, 2'b10);
    for (int k = 0; k < 4; k++) begin
      raw_in[0] = (k % 2 == 0);
      wait_cycles(2);
    end
    raw_in[0] = 1'b1;
    expect_event(LAT, 2'b01, 2'b00);
    drain("drain_bounce");
    check("t2_clean", clean_out, 2'b11);

    // 3. Short glitch on channel 1 is rejected, a longer pulse is not.
    raw_in = 2'b01;
    expect_event(LAT, 2'b00, 2'b10);
    drain("drain_fall1");
    raw_in = 2'b11;
    wait_cycles(DEB - 1);
    raw_in = 2'b01;
    wait_cycles(10);
    check("glitch_clean", clean_out, 2'b01);
    check("glitch_q", exp_q.size(), 0);
    raw_in = 2'b11;
    expect_event(LAT, 2'b10, 2'b00);
    wait_cycles(DEB + 1);
    raw_in = 2'b01;
    expect_event(LAT, 2'b00, 2'b10);
    drain("drain_long");
    check("t3_clean", clean_out, 2'b01);

    // 4. Opposite changes on both channels in the same cycle.
    raw_in = 2'b10;
    expect_event(LAT, 2'b10, 2'b01);
    drain("drain_simul");
    check("t4_clean", clean_out, 2'b10);

    // 5. Enable freeze mid-count: 2 counts done, 10 frozen cycles.
    raw_in = 2'b11;
    expect_event(LAT + 10, 2'b01, 2'b00);
    wait_cycles(SYNC + 2);
    ena = 1'b0;
    wait_cycles(10);
    check("freeze_clean", clean_out, 2'b10);
    ena = 1'b1;
    drain("drain_freeze");
    check("t5_clean", clean_out, 2'b11);

    // 6a. Reset mid-count clears outputs before the next clock edge.
    raw_in = 2'b00;
    wait_cycles(SYNC + 2);
    #2 rst_n = 1'b0;
    #1;
    check("async_clean", clean_out, 0);
    check("async_any", any_change, 0);
    #1 rst_n = 1'b1;
    wait_cycles(10);
    check("t6a_clean", clean_out, 2'b00);
    // 6b. A high input interrupted by reset restarts from scratch.
    raw_in = 2'b11;
    wait_cycles(SYNC + 2);
    #2 rst_n = 1'b0;
    #1;
    check("async_clean2", clean_out, 0);
    #1 rst_n = 1'b1;
    expect_event(LAT, 2'b11, 2'b00);
    drain("drain_restart");
    check("t6_clean", clean_out, 2'b11);

    wait_cycles(3);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
